bcd_to_ex3_serializer: RTL and testbench



---
 rtl/bcd_to_ex3_serializer.sv | 167 ++++++++++++++++
 tb/tb_bcd_to_ex3_serializer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_ex3_serializer.sv
// bcd_to_ex3_serializer
// Accepts parallel BCD digits over valid/ready, converts each to Excess-3
// and shifts the 4-bit code out on a single serial line, one bit per clock,
// with back-to-back frames and no idle gap between queued digits.
// A one-entry holding register (stage p0) decouples the producer from the
// shifter (stage p1).
// Optional feature macro: BCD2EX3_IDLE_FILL_EN -- when defined, the shifter
// never idles and emits fill frames 0011 (Excess-3 of 0) with frame=0, busy=0.
`timescale 1ns/1ps
module bcd_to_ex3_serializer #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] bcd_in,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       outp,
   output logic       frame,
   output logic       busy,
   output logic       err
);

   localparam int         DATA_W    = 4;
   localparam logic [3:0] FILL_CODE = 4'd3;
`ifdef BCD2EX3_IDLE_FILL_EN
   localparam bit         FILL_EN   = 1'b1;
`else
   localparam bit         FILL_EN   = 1'b0;
`endif

   typedef enum logic [0:0] {IDLE, SHIFT} state_t;

   state_t              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;

   // stage p0: holding register (stores the already-encoded Excess-3 code)
   logic [DATA_W-1:0]   hold_p0;
   logic                vld_p0;

   // stage p1: shift register holding the not-yet-emitted bits of a frame
   logic [DATA_W-1:0]   sh_p1, sh_d;

   logic                outp_d, frame_d, busy_d;
   logic                take_p0;
   logic                load;
   logic                accept;
   logic [DATA_W-1:0]   load_code;

   // Excess-3 encode; invalid digits (10..15) are replaced by 0 -> 0011
   function automatic logic [DATA_W-1:0] ex3_encode(input logic [DATA_W-1:0] d);
      if (d > 4'd9)
         return 4'd3;
      else
         return d + 4'd3;
   endfunction

   function automatic logic bcd_invalid(input logic [DATA_W-1:0] d);
      return (d > 4'd9);
   endfunction

   // bit that goes on the line when a code is loaded or shifted
   function automatic logic first_bit(input logic [DATA_W-1:0] c);
      return LSB_FIRST ? c[0] : c[DATA_W-1];
   endfunction

   // remaining bits after the leading one has been emitted
   function automatic logic [DATA_W-1:0] after_first(input logic [DATA_W-1:0] c);
      return LSB_FIRST ? {1'b0, c[DATA_W-1:1]} : {c[DATA_W-2:0], 1'b0};
   endfunction

   assign in_ready  = ~vld_p0;
   assign accept    = in_valid & in_ready;
   assign load_code = vld_p0 ? hold_p0 : FILL_CODE;

   // next-state and registered-output decode for the shifter FSM
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_p1;
      outp_d  = outp;
      frame_d = 1'b0;
      busy_d  = busy;
      take_p0 = 1'b0;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (vld_p0 || FILL_EN) begin
               load = 1'b1;
            end else begin
               outp_d = 1'b0;
               busy_d = 1'b0;
            end
         end
         SHIFT: begin
            if (cnt_q != 2'd3) begin
               outp_d = first_bit(sh_p1);
               sh_d   = after_first(sh_p1);
               cnt_d  = cnt_q + 2'd1;
            end else if (vld_p0 || FILL_EN) begin
               load = 1'b1;
            end else begin
               state_d = IDLE;
               cnt_d   = 2'd0;
               outp_d  = 1'b0;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 2'd0;
            outp_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
      // a frame boundary load: real digit from hold, or a fill frame
      if (load) begin
         state_d = SHIFT;
         cnt_d   = 2'd0;
         outp_d  = first_bit(load_code);
         sh_d    = after_first(load_code);
         frame_d = vld_p0;
         busy_d  = vld_p0;
         take_p0 = vld_p0;
      end
   end

   // FSM state, bit counter and registered serial outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         outp    <= 1'b0;
         frame   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         outp    <= outp_d;
         frame   <= frame_d;
         busy    <= busy_d;
      end
   end

   // holding-register occupancy and sticky invalid-digit flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p0 <= 1'b0;
         err    <= 1'b0;
      end else begin
         if (accept)
            vld_p0 <= 1'b1;
         else if (take_p0)
            vld_p0 <= 1'b0;
         if (accept && bcd_invalid(bcd_in))
            err <= 1'b1;
      end
   end

   // data path registers; qualified by vld_p0 / FSM state, so no reset
   always_ff @(posedge clk) begin
      if (accept)
         hold_p0 <= ex3_encode(bcd_in);
      sh_p1 <= sh_d;
   end

endmodule

// File: tb/tb_bcd_to_ex3_serializer.sv
// Self-checking bench for bcd_to_ex3_serializer: an LSB-first and an
// MSB-first instance share the same stimulus; every accepted digit pushes
// its expected Excess-3 code to a per-instance queue, and a monitor on each
// instance reassembles real-digit frames and compares them. Hand-written
// sequences cover cycle-exact latency, back-to-back frames and reset abort.
`timescale 1ns/1ps
module tb_bcd_to_ex3_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] bcd_in = 4'd0;
   logic       in_valid = 1'b0;

   logic in_ready, outp, frame, busy, err;
   logic in_ready_m, outp_m, frame_m, busy_m, err_m;

   int checks = 0;
   int failures = 0;

   logic [3:0] exp_q[$];
   logic [3:0] exp_qm[$];

   typedef struct packed {
      logic [3:0] bcd;
      logic [3:0] code;
      logic       err;
   } vec_t;

   vec_t tbl[12];

   always #5 clk = ~clk;

   bcd_to_ex3_serializer #(.LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst(rst), .bcd_in(bcd_in), .in_valid(in_valid),
      .in_ready(in_ready), .outp(outp), .frame(frame), .busy(busy), .err(err)
   );

   bcd_to_ex3_serializer #(.LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst(rst), .bcd_in(bcd_in), .in_valid(in_valid),
      .in_ready(in_ready_m), .outp(outp_m), .frame(frame_m), .busy(busy_m), .err(err_m)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic sb_compare(input string name, input logic [3:0] got, input bit msb);
      logic [3:0] e;
      if ((msb ? exp_qm.size() : exp_q.size()) == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_unexpected: got frame %0h expected none at %0t", name, got, $time);
      end else begin
         e = msb ? exp_qm.pop_front() : exp_q.pop_front();
         check(name, got, e);
      end
   endtask

   // frame monitor, LSB-first instance: bit i of the code arrives i-th
   int         mon_n = 0;
   logic [3:0] mon_b;
   always @(negedge clk) begin
      if (!rst) begin
         mon_n = 0;
      end else if (frame) begin
         mon_b[0] = outp;
         mon_n = 1;
      end else if (mon_n != 0) begin
         mon_b[mon_n] = outp;
         mon_n++;
         if (mon_n == 4) begin
            mon_n = 0;
            sb_compare("sb_lsb", mon_b, 1'b0);
         end
      end
   end

   // frame monitor, MSB-first instance: bit 3 of the code arrives first
   int         mon_nm = 0;
   logic [3:0] mon_bm;
   always @(negedge clk) begin
      if (!rst) begin
         mon_nm = 0;
      end else if (frame_m) begin
         mon_bm[0] = outp_m;
         mon_nm = 1;
      end else if (mon_nm != 0) begin
         mon_bm[mon_nm] = outp_m;
         mon_nm++;
         if (mon_nm == 4) begin
            mon_nm = 0;
            sb_compare("sb_msb", {mon_bm[0], mon_bm[1], mon_bm[2], mon_bm[3]}, 1'b1);
         end
      end
   end

   // present a digit, wait (bounded) for ready, return 1ns after the accept edge
   task automatic send(input logic [3:0] d, input logic [3:0] code);
      int t = 0;
      bcd_in   = d;
      in_valid = 1'b1;
      while (!in_ready && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready %0b expected 1 at %0t", in_ready, $time);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      exp_q.push_back(code);
      exp_qm.push_back(code);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] o_exp, f_exp, r_exp, b_exp, m_exp;
      int w;

      tbl[0]  = '{4'd0,  4'd3,  1'b0};
      tbl[1]  = '{4'd9,  4'd12, 1'b0};
      tbl[2]  = '{4'd5,  4'd8,  1'b0};
      tbl[3]  = '{4'd1,  4'd4,  1'b0};
      tbl[4]  = '{4'd4,  4'd7,  1'b0};
      tbl[5]  = '{4'd8,  4'd11, 1'b0};
      tbl[6]  = '{4'd2,  4'd5,  1'b0};
      tbl[7]  = '{4'd12, 4'd3,  1'b1};
      tbl[8]  = '{4'd3,  4'd6,  1'b1};
      tbl[9]  = '{4'd15, 4'd3,  1'b1};
      tbl[10] = '{4'd6,  4'd9,  1'b1};
      tbl[11] = '{4'd10, 4'd3,  1'b1};

      // reset state
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outp", outp, 1'b0);
      check("rst_frame", frame, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      rst = 1'b1;

`ifdef BCD2EX3_IDLE_FILL_EN
      // fill frames 1,1,0,0 from the first edge after release
      o_exp = 8'b0011_0011;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("fill_outp_%0d", k), outp, o_exp[k]);
         check($sformatf("fill_fb_%0d", k), {frame, busy}, 2'b00);
      end
      @(posedge clk);
      #1;
      // digit 4 accepted mid-fill, loaded at the next frame boundary
      send(4'd4, 4'd7);
      w = 0;
      do begin
         @(posedge clk);
         #1;
         w++;
      end while (!frame && w < 8);
      check("fill_latency", w, 3);
      o_exp = 8'b0000_0111;
      for (int k = 0; k < 4; k++) begin
         if (k != 0) begin
            @(posedge clk);
            #1;
         end
         check($sformatf("fill_dig_outp_%0d", k), outp, o_exp[k]);
         check($sformatf("fill_dig_fb_%0d", k), {frame, busy}, {(k == 0), 1'b1});
      end
      @(posedge clk);
      #1;
      check("fill_resume", {outp, frame, busy}, 3'b100);
`else
      @(posedge clk);
      #1;
      check("idle_after_rst", {outp, frame, busy}, 3'b000);

      // digit 5 (code 1000) with the shifter idle
      send(4'd5, 4'd8);
      check("d5_in_ready_full", in_ready, 1'b0);
      o_exp = 8'b0000_1000;
      f_exp = 8'b0000_0001;
      b_exp = 8'b0000_1111;
      m_exp = 8'b0000_0001;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("d5_outp_%0d", k), outp, o_exp[k-1]);
         check($sformatf("d5_frame_%0d", k), frame, f_exp[k-1]);
         check($sformatf("d5_busy_%0d", k), busy, b_exp[k-1]);
         check($sformatf("d5_outp_msb_%0d", k), outp_m, m_exp[k-1]);
         if (k == 1) check("d5_in_ready_drained", in_ready, 1'b1);
      end

      // back-to-back 0 then 9 with in_valid held high
      bcd_in   = 4'd0;
      in_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(4'd3);
      exp_qm.push_back(4'd3);
      #1;
      check("b2b_in_ready_0", in_ready, 1'b0);
      bcd_in = 4'd9;
      o_exp = 8'b1100_0011;
      f_exp = 8'b0001_0001;
      r_exp = 8'b1111_0001;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (k == 2) begin
            exp_q.push_back(4'd12);
            exp_qm.push_back(4'd12);
            in_valid = 1'b0;
         end
         check($sformatf("b2b_outp_%0d", k), outp, o_exp[k-1]);
         check($sformatf("b2b_frame_%0d", k), frame, f_exp[k-1]);
         check($sformatf("b2b_in_ready_%0d", k), in_ready, r_exp[k-1]);
         check($sformatf("b2b_busy_%0d", k), busy, 1'b1);
      end
      @(posedge clk);
      #1;
      check("b2b_end_idle", {outp, busy}, 2'b00);

      // MSB-first instance, digit 2 (code 0101) -> 0,1,0,1
      send(4'd2, 4'd5);
      m_exp = 8'b0000_1010;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("msb_d2_outp_%0d", k), outp_m, m_exp[k-1]);
         check($sformatf("msb_d2_frame_%0d", k), frame_m, (k == 1));
      end
      repeat (2) @(posedge clk);
      #1;
`endif

      // table of digits, back-to-back, with sticky err tracking
      for (int i = 0; i < 12; i++) begin
         send(tbl[i].bcd, tbl[i].code);
         check($sformatf("tbl_err_%0d", i), err, tbl[i].err);
      end
      w = 0;
      while ((exp_q.size() != 0 || exp_qm.size() != 0) && w < 200) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("tbl_drain_lsb", exp_q.size(), 0);
      check("tbl_drain_msb", exp_qm.size(), 0);
      check("err_sticky", err, 1'b1);

`ifndef BCD2EX3_IDLE_FILL_EN
      repeat (3) @(posedge clk);
      #1;
      // reset mid-frame: digit 7 (code 1010) shifting, digit 1 held
      send(4'd7, 4'd10);
      send(4'd1, 4'd4);
      check("abort_pre_outp", {outp, frame, busy}, 3'b101);
      rst = 1'b0;
      #1;
      check("abort_outp", outp, 1'b0);
      check("abort_frame", frame, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_in_ready", in_ready, 1'b1);
      check("abort_err_clr", err, 1'b0);
      exp_q.delete();
      exp_qm.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("abort_quiet_%0d", k), {outp, frame, busy, outp_m, frame_m}, 5'b00000);
      end
`endif

      check("final_q_lsb", exp_q.size(), 0);
      check("final_q_msb", exp_qm.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
